// File: rtl/assoc_cache.sv
// 2-way set-associative, write-through, no-write-allocate data cache with one-word lines.
// Hits answer combinationally; misses and stores stall the core while a memory transaction runs.
module assoc_cache #(
  parameter int DATA_WIDTH    = 32,
  parameter int ADDRESS_WIDTH = 30,
  parameter int SET_BITS      = 3
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cpu_req,
  input  logic                     cpu_we,
  input  logic [ADDRESS_WIDTH-1:0] cpu_addr,
  input  logic [DATA_WIDTH-1:0]    cpu_wdata,
  input  logic                     flush,
  output logic [DATA_WIDTH-1:0]    cpu_rdata,
  output logic                     cpu_ready,
  output logic                     mem_req,
  output logic                     mem_we,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  input  logic                     mem_ack,
  output logic [31:0]              hit_count,
  output logic [31:0]              miss_count
);

  localparam int SETS  = 1 << SET_BITS;
  localparam int TAG_W = ADDRESS_WIDTH - SET_BITS;

  typedef enum logic [1:0] {IDLE, FILL, WRITE} state_t;

  state_t state, state_next;

  logic [SETS-1:0]       valid [2];
  logic [SETS-1:0]       lru;
  logic [TAG_W-1:0]      tag_mem  [2][SETS];
  logic [DATA_WIDTH-1:0] data_mem [2][SETS];

  logic                  wr_hit;
  logic                  wr_way;
  logic                  just_filled;

  logic [SET_BITS-1:0]   idx, m_idx;
  logic [TAG_W-1:0]      req_tag, m_tag;
  logic                  hit0, hit1, hit, hit_way, fill_way;
  logic [DATA_WIDTH-1:0] hit_data;

  assign idx      = cpu_addr[SET_BITS-1:0];
  assign req_tag  = cpu_addr[ADDRESS_WIDTH-1:SET_BITS];
  assign m_idx    = mem_addr[SET_BITS-1:0];
  assign m_tag    = mem_addr[ADDRESS_WIDTH-1:SET_BITS];

  assign hit0     = valid[0][idx] && (tag_mem[0][idx] == req_tag);
  assign hit1     = valid[1][idx] && (tag_mem[1][idx] == req_tag);
  assign hit      = cpu_req && (hit0 || hit1);
  assign hit_way  = hit1;
  assign hit_data = hit1 ? data_mem[1][idx] : data_mem[0][idx];

  assign mem_req  = (state != IDLE);
  assign mem_we   = (state == WRITE);

  // Empty ways are filled before anything is evicted; way0 wins when both are empty.
  always_comb begin
    fill_way = lru[m_idx];
    if (!valid[0][m_idx])
      fill_way = 1'b0;
    else if (!valid[1][m_idx])
      fill_way = 1'b1;
  end

  always_comb begin
    state_next = state;
    cpu_ready  = 1'b0;
    cpu_rdata  = '0;
    unique case (state)
      IDLE: begin
        if (cpu_req) begin
          if (cpu_we) begin
            state_next = WRITE;
          end else if (hit) begin
            cpu_ready = 1'b1;
            cpu_rdata = hit_data;
          end else begin
            state_next = FILL;
          end
        end
      end
      FILL: begin
        if (mem_ack) state_next = IDLE;
      end
      WRITE: begin
        if (mem_ack) begin
          cpu_ready  = 1'b1;
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // The hit that completes a refilled load is flagged by just_filled so it is not counted twice.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      valid[0]    <= '0;
      valid[1]    <= '0;
      lru         <= '0;
      hit_count   <= '0;
      miss_count  <= '0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      wr_hit      <= 1'b0;
      wr_way      <= 1'b0;
      just_filled <= 1'b0;
    end else begin
      state       <= state_next;
      just_filled <= 1'b0;
      unique case (state)
        IDLE: begin
          if (cpu_req) begin
            if (cpu_we) begin
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
              wr_hit    <= hit;
              wr_way    <= hit_way;
              if (hit) hit_count  <= hit_count + 32'd1;
              else     miss_count <= miss_count + 32'd1;
            end else if (hit) begin
              lru[idx] <= ~hit_way;
              if (!just_filled) hit_count <= hit_count + 32'd1;
            end else begin
              mem_addr   <= cpu_addr;
              miss_count <= miss_count + 32'd1;
            end
          end else if (flush) begin
            valid[0] <= '0;
            valid[1] <= '0;
            lru      <= '0;
          end
        end
        FILL: begin
          if (mem_ack) begin
            valid[fill_way][m_idx] <= 1'b1;
            lru[m_idx]             <= ~fill_way;
            just_filled            <= 1'b1;
          end
        end
        WRITE: begin
          if (mem_ack && wr_hit) lru[m_idx] <= ~wr_way;
        end
        default: ;
      endcase
    end
  end

  // Tag/data storage needs no reset: nothing is read unless its valid bit is set.
  always_ff @(posedge clk) begin
    if (state == FILL && mem_ack) begin
      tag_mem[fill_way][m_idx]  <= m_tag;
      data_mem[fill_way][m_idx] <= mem_rdata;
    end else if (state == WRITE && mem_ack && wr_hit) begin
      data_mem[wr_way][m_idx] <= mem_wdata;
    end
  end

endmodule
